// File: rtl/rr_arbiter16_pkg.sv
// Shared constants and FSM state type for the 16-way round-robin arbiter.
package rr_arbiter16_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter16_pick.sv
// rr_pick16: combinational round-robin picker; first eligible request at or after ptr (mod 16).
module rr_pick16
  import rr_arbiter16_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] winIdx,
  output logic             any
);

  logic [N_REQ-1:0]   elig;
  logic [2*N_REQ-1:0] dbl_fwd;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_win;
  logic [2*N_REQ-1:0] dbl_back;
  logic [IDX_W-1:0]   first;
  logic               found;

  always_comb begin
    // mask bits are excluded from the search (e.g. the owner being revoked)
    elig    = req & ~mask;
    dbl_fwd = {elig, elig} >> ptr;
    rot     = dbl_fwd[N_REQ-1:0];
    found   = 1'b0;
    first   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        first = IDX_W'(i);
      end
    end
    rot_win  = found ? (N_REQ'(1) << first) : '0;
    dbl_back = {rot_win, rot_win} << ptr;
    win      = dbl_back[2*N_REQ-1:N_REQ];
    winIdx   = found ? first + ptr : '0;
    any      = found;
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter with registered one-hot grant locked to its owner until release.
// Optional hold-timeout preemption is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gntIdx,
  output logic             gntValid,
  output logic             preempt
);

  if (2**CNT_W <= HOLD_MAX) begin : g_cfg_err
    $error("rr_arbiter16: CNT_W too narrow for HOLD_MAX");
  end

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             preempt_q, preempt_d;

  logic [N_REQ-1:0] win;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic [IDX_W-1:0] pick_ptr;

  // While granted, search starts after the owner and excludes it, so a
  // released or revoked owner always falls to lowest priority.
  assign pick_ptr = (state_q == ST_GRANT) ? idx_q + IDX_W'(1) : ptr_q;

  rr_pick16 u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .mask   (gnt_q),
    .win    (win),
    .winIdx (win_idx),
    .any    (win_any)
  );

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q, hold_d;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      preempt_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      preempt_q <= preempt_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    preempt_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (en && win_any) begin
          state_d = ST_GRANT;
          gnt_d   = win;
          idx_d   = win_idx;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!req[idx_q]) begin
          ptr_d = idx_q + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
          hold_d = '0;
`endif
          if (en && win_any) begin
            gnt_d = win;
            idx_d = win_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == CNT_W'(HOLD_MAX) && en && win_any) begin
          ptr_d     = idx_q + IDX_W'(1);
          gnt_d     = win;
          idx_d     = win_idx;
          preempt_d = 1'b1;
          hold_d    = '0;
        end else if (hold_q != CNT_W'(HOLD_MAX)) begin
          hold_d = hold_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    gnt      = gnt_q;
    gntIdx   = idx_q;
    gntValid = |gnt_q;
    preempt  = preempt_q;
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed self-checking bench for rr_arbiter16; timeout scenario selected by ARB_TIMEOUT_EN.
module tb_rr_arbiter16;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gntIdx;
  logic        gntValid;
  logic        preempt;

  int unsigned tests_run;
  int unsigned failed;

  rr_arbiter16 #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .gntIdx   (gntIdx),
    .gntValid (gntValid),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; req = 16'h0000;
    repeat (2) tick();
    tests_run++;
    if (gnt !== 16'h0000 || gntIdx !== 4'd0 || gntValid !== 1'b0 || preempt !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: gnt=%h idx=%0d valid=%b preempt=%b, want 0000/0/0/0",
               gnt, gntIdx, gntValid, preempt);
    end
    #2 rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests_run++;
      if (gnt !== 16'h0000 || gntValid !== 1'b0) begin
        failed++;
        $display("FAIL idle_no_req cycle %0d: gnt=%h valid=%b, want 0000/0", c, gnt, gntValid);
      end
    end
  endtask

  task automatic test_single();
    req = 16'h0008;
    tick();
    tests_run++;
    if (gnt !== 16'h0008 || gntIdx !== 4'd3 || gntValid !== 1'b1) begin
      failed++;
      $display("FAIL single_grant: gnt=%h idx=%0d valid=%b, want 0008/3/1", gnt, gntIdx, gntValid);
    end
    req = 16'h0000;
    tick();
    tests_run++;
    if (gnt !== 16'h0000 || gntIdx !== 4'd0 || gntValid !== 1'b0) begin
      failed++;
      $display("FAIL single_release: gnt=%h idx=%0d valid=%b, want 0000/0/0", gnt, gntIdx, gntValid);
    end
  endtask

  task automatic test_async_reset();
    req = 16'h0008;
    tick();
    tests_run++;
    if (gnt !== 16'h0008) begin
      failed++;
      $display("FAIL pre_reset_grant: gnt=%h, want 0008", gnt);
    end
    #3 rstn = 1'b0;
    #1;
    tests_run++;
    if (gnt !== 16'h0000 || gntValid !== 1'b0) begin
      failed++;
      $display("FAIL async_reset_drop: gnt=%h valid=%b, want 0000/0", gnt, gntValid);
    end
    req = 16'h0000;
    tick();
    #2 rstn = 1'b1;
    tick();
  endtask

  task automatic test_rotation();
    logic [15:0] exp_gnt;
    req = 16'hFFFF;
    tick();
    for (int i = 0; i < 17; i++) begin
      exp_gnt = 16'h0001 << (i % 16);
      tests_run++;
      if (gnt !== exp_gnt || gntIdx !== 4'(i % 16) || gntValid !== 1'b1) begin
        failed++;
        $display("FAIL rotation_grant step %0d: gnt=%h idx=%0d, want %h/%0d", i, gnt, gntIdx, exp_gnt, i % 16);
      end
      tick();
      tests_run++;
      if (gnt !== exp_gnt) begin
        failed++;
        $display("FAIL rotation_hold step %0d: gnt=%h, want %h", i, gnt, exp_gnt);
      end
      req[i % 16] = 1'b0;
      tick();
      req[i % 16] = 1'b1;
    end
    req = 16'h0000;
    tick();
    tests_run++;
    if (gnt !== 16'h0000) begin
      failed++;
      $display("FAIL rotation_end_idle: gnt=%h, want 0000", gnt);
    end
  endtask

  // ptr is 2 on entry (last owner was 1)
  task automatic test_wrap_order();
    req = 16'h0020;
    tick();
    tests_run++;
    if (gnt !== 16'h0020 || gntIdx !== 4'd5) begin
      failed++;
      $display("FAIL wrap_owner5: gnt=%h idx=%0d, want 0020/5", gnt, gntIdx);
    end
    req = 16'h0031;
    tick();
    tests_run++;
    if (gnt !== 16'h0020) begin
      failed++;
      $display("FAIL wrap_hold5: gnt=%h, want 0020", gnt);
    end
    req = 16'h0011;
    tick();
    tests_run++;
    if (gnt !== 16'h0001 || gntIdx !== 4'd0) begin
      failed++;
      $display("FAIL wrap_next0: gnt=%h idx=%0d, want 0001/0", gnt, gntIdx);
    end
    req = 16'h0010;
    tick();
    tests_run++;
    if (gnt !== 16'h0010 || gntIdx !== 4'd4) begin
      failed++;
      $display("FAIL wrap_then4: gnt=%h idx=%0d, want 0010/4", gnt, gntIdx);
    end
    req = 16'h0000;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  // ptr is 5 on entry; HOLD_MAX=4
  task automatic test_timeout();
    req = 16'h0004;
    tick();
    req = 16'h0204;
    for (int c = 1; c <= 4; c++) begin
      tick();
      tests_run++;
      if (gnt !== 16'h0004 || preempt !== 1'b0) begin
        failed++;
        $display("FAIL timeout_hold cycle %0d: gnt=%h preempt=%b, want 0004/0", c, gnt, preempt);
      end
    end
    tick();
    tests_run++;
    if (gnt !== 16'h0200 || gntIdx !== 4'd9 || preempt !== 1'b1) begin
      failed++;
      $display("FAIL timeout_preempt: gnt=%h idx=%0d preempt=%b, want 0200/9/1", gnt, gntIdx, preempt);
    end
    tick();
    tests_run++;
    if (gnt !== 16'h0200 || preempt !== 1'b0) begin
      failed++;
      $display("FAIL timeout_pulse_end: gnt=%h preempt=%b, want 0200/0", gnt, preempt);
    end
    req = 16'h0004;
    tick();
    for (int c = 0; c < 8; c++) begin
      tick();
      tests_run++;
      if (gnt !== 16'h0004 || preempt !== 1'b0) begin
        failed++;
        $display("FAIL timeout_alone cycle %0d: gnt=%h preempt=%b, want 0004/0", c, gnt, preempt);
      end
    end
    req = 16'h0000;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    req = 16'h0004;
    tick();
    req = 16'h0204;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests_run++;
      if (gnt !== 16'h0004 || preempt !== 1'b0) begin
        failed++;
        $display("FAIL no_timeout_hold cycle %0d: gnt=%h preempt=%b, want 0004/0", c, gnt, preempt);
      end
    end
    req = 16'h0200;
    tick();
    tests_run++;
    if (gnt !== 16'h0200 || gntIdx !== 4'd9) begin
      failed++;
      $display("FAIL no_timeout_handoff: gnt=%h idx=%0d, want 0200/9", gnt, gntIdx);
    end
    req = 16'h0000;
    tick();
  endtask
`endif

  task automatic test_enable();
    #2 rstn = 1'b0;
    tick();
    #2 rstn = 1'b1;
    en  = 1'b0;
    req = 16'h0101;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (gnt !== 16'h0000) begin
        failed++;
        $display("FAIL en_low_no_grant cycle %0d: gnt=%h, want 0000", c, gnt);
      end
    end
    en = 1'b1;
    tick();
    tests_run++;
    if (gnt !== 16'h0001 || gntIdx !== 4'd0) begin
      failed++;
      $display("FAIL en_high_grant: gnt=%h idx=%0d, want 0001/0", gnt, gntIdx);
    end
    en = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (gnt !== 16'h0001) begin
      failed++;
      $display("FAIL en_low_keep_owner: gnt=%h, want 0001", gnt);
    end
    req = 16'h0100;
    tick();
    tests_run++;
    if (gnt !== 16'h0000 || gntValid !== 1'b0) begin
      failed++;
      $display("FAIL en_low_release_idle: gnt=%h valid=%b, want 0000/0", gnt, gntValid);
    end
    en = 1'b1;
    tick();
    tests_run++;
    if (gnt !== 16'h0100 || gntIdx !== 4'd8) begin
      failed++;
      $display("FAIL en_restore_grant: gnt=%h idx=%0d, want 0100/8", gnt, gntIdx);
    end
    req = 16'h0000;
    tick();
  endtask

  initial begin
    tests_run = 0;
    failed    = 0;
    test_reset();
    test_single();
    test_async_reset();
    test_rotation();
    test_wrap_order();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
